// File: rtl/lpc_host_if.sv
// Request/response handshake and LPC pin bundle for the LPC host.
// The master view belongs to lpc_host; the slave view is the requester plus peripheral side.
interface lpc_host_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_cyctype_dir;
  logic [31:0] req_addr;
  logic [7:0]  req_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_error;
  logic        lpc_frame;
  logic [3:0]  lpc_ad_out;
  logic        lpc_ad_oe;
  logic [3:0]  lpc_ad_in;

  modport master (
    input  req_valid, req_cyctype_dir, req_addr, req_data, lpc_ad_in,
    output req_ready, rsp_valid, rsp_data, rsp_error, lpc_frame, lpc_ad_out, lpc_ad_oe
  );

  modport slave (
    output req_valid, req_cyctype_dir, req_addr, req_data, lpc_ad_in,
    input  req_ready, rsp_valid, rsp_data, rsp_error, lpc_frame, lpc_ad_out, lpc_ad_oe
  );
endinterface

// File: rtl/lpc_host.sv
// LPC bus initiator: runs one single-byte I/O or memory cycle per accepted request
// and returns read data or an error status.
module lpc_host #(
  parameter int SYNC_TIMEOUT = 8,
  parameter int LWAIT_MAX    = 64
) (
  input  logic       lpc_clock,
  input  logic       lpc_reset,
  lpc_host_if.master bus
);

  localparam int TO_W = $clog2(SYNC_TIMEOUT + 1);
  localparam int LW_W = $clog2(LWAIT_MAX + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(SYNC_TIMEOUT - 1);
  localparam logic [LW_W-1:0] LW_LAST = LW_W'(LWAIT_MAX);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_CTDIR, S_ADDR, S_WDATA, S_HTAR1, S_HTAR2, S_SYNC,
    S_RDATA, S_PTAR1, S_PTAR2, S_ABORT, S_ABORT_END, S_DONE
  } state_t;

  state_t            state_r;
  logic [3:0]        ctdir_r;
  logic [31:0]       addr_r;
  logic [7:0]        wdata_r;
  logic [7:0]        rdata_r;
  logic [2:0]        nib_cnt_r;
  logic              err_r;
  logic [TO_W-1:0]   to_cnt_r;
  logic [LW_W-1:0]   lw_cnt_r;
  logic              frame_r;
  logic [3:0]        ad_out_r;
  logic              ad_oe_r;
  logic              rsp_valid_r;
  logic [7:0]        rsp_data_r;
  logic              rsp_error_r;
  logic [2:0]        nib_dec_s;

  function automatic logic [3:0] addr_nibble(input logic [31:0] a, input logic [2:0] idx);
    addr_nibble = a[{idx, 2'b00} +: 4];
  endfunction

  function automatic logic is_write(input logic [3:0] ct);
    is_write = ct[1];
  endfunction

  function automatic logic is_mem(input logic [3:0] ct);
    is_mem = (ct[3:2] == 2'b01);
  endfunction

  assign nib_dec_s       = nib_cnt_r - 3'd1;
  assign bus.req_ready   = (state_r == S_IDLE) && !lpc_reset;
  assign bus.lpc_frame   = frame_r;
  assign bus.lpc_ad_out  = ad_out_r;
  assign bus.lpc_ad_oe   = ad_oe_r;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_data    = rsp_data_r;
  assign bus.rsp_error   = rsp_error_r;

  // Cycle sequencer; every pin value is registered on entry to the state it belongs to.
  always_ff @(posedge lpc_clock) begin
    if (lpc_reset) begin
      state_r     <= S_IDLE;
      ctdir_r     <= 4'h0;
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 8'h00;
      rdata_r     <= 8'h00;
      nib_cnt_r   <= 3'd0;
      err_r       <= 1'b0;
      to_cnt_r    <= '0;
      lw_cnt_r    <= '0;
      frame_r     <= 1'b1;
      ad_out_r    <= 4'hF;
      ad_oe_r     <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 8'h00;
      rsp_error_r <= 1'b0;
    end else begin
      rsp_valid_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (bus.req_valid) begin
            ctdir_r  <= bus.req_cyctype_dir;
            addr_r   <= bus.req_addr;
            wdata_r  <= bus.req_data;
            rdata_r  <= 8'h00;
            err_r    <= 1'b0;
            state_r  <= S_START;
            frame_r  <= 1'b0;
            ad_out_r <= 4'h0;
            ad_oe_r  <= 1'b1;
          end else begin
            frame_r  <= 1'b1;
            ad_out_r <= 4'hF;
            ad_oe_r  <= 1'b0;
          end
        end
        S_START: begin
          state_r  <= S_CTDIR;
          frame_r  <= 1'b1;
          ad_out_r <= ctdir_r;
        end
        S_CTDIR: begin
          state_r   <= S_ADDR;
          nib_cnt_r <= is_mem(ctdir_r) ? 3'd7 : 3'd3;
          ad_out_r  <= addr_nibble(addr_r, is_mem(ctdir_r) ? 3'd7 : 3'd3);
        end
        S_ADDR: begin
          if (nib_cnt_r != 3'd0) begin
            nib_cnt_r <= nib_dec_s;
            ad_out_r  <= addr_nibble(addr_r, nib_dec_s);
          end else if (is_write(ctdir_r)) begin
            state_r   <= S_WDATA;
            nib_cnt_r <= 3'd1;
            ad_out_r  <= wdata_r[3:0];
          end else begin
            state_r  <= S_HTAR1;
            ad_out_r <= 4'hF;
          end
        end
        S_WDATA: begin
          if (nib_cnt_r != 3'd0) begin
            nib_cnt_r <= 3'd0;
            ad_out_r  <= wdata_r[7:4];
          end else begin
            state_r  <= S_HTAR1;
            ad_out_r <= 4'hF;
          end
        end
        S_HTAR1: begin
          state_r <= S_HTAR2;
          ad_oe_r <= 1'b0;
        end
        S_HTAR2: begin
          state_r  <= S_SYNC;
          to_cnt_r <= '0;
          lw_cnt_r <= '0;
        end
        S_SYNC: begin
          case (bus.lpc_ad_in)
            4'b0000, 4'b1010: begin
              err_r     <= (bus.lpc_ad_in == 4'b1010);
              nib_cnt_r <= 3'd1;
              state_r   <= is_write(ctdir_r) ? S_PTAR1 : S_RDATA;
            end
            4'b0101: begin
              to_cnt_r <= '0;
            end
            4'b0110: begin
              // Long wait is bounded separately so a stuck peripheral still ends the cycle.
              if (lw_cnt_r >= LW_LAST) begin
                state_r   <= S_ABORT;
                nib_cnt_r <= 3'd3;
                frame_r   <= 1'b0;
                ad_out_r  <= 4'hF;
                ad_oe_r   <= 1'b1;
              end else begin
                lw_cnt_r <= lw_cnt_r + LW_W'(1);
              end
            end
            default: begin
              if (to_cnt_r >= TO_LAST) begin
                state_r   <= S_ABORT;
                nib_cnt_r <= 3'd3;
                frame_r   <= 1'b0;
                ad_out_r  <= 4'hF;
                ad_oe_r   <= 1'b1;
              end else begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
              end
            end
          endcase
        end
        S_RDATA: begin
          if (nib_cnt_r != 3'd0) begin
            nib_cnt_r    <= 3'd0;
            rdata_r[3:0] <= bus.lpc_ad_in;
          end else begin
            rdata_r[7:4] <= bus.lpc_ad_in;
            state_r      <= S_PTAR1;
          end
        end
        S_PTAR1: begin
          state_r <= S_PTAR2;
        end
        S_PTAR2: begin
          state_r     <= S_DONE;
          rsp_valid_r <= 1'b1;
          rsp_data_r  <= rdata_r;
          rsp_error_r <= err_r;
        end
        S_ABORT: begin
          if (nib_cnt_r != 3'd0) begin
            nib_cnt_r <= nib_dec_s;
          end else begin
            state_r <= S_ABORT_END;
            frame_r <= 1'b1;
            ad_oe_r <= 1'b0;
          end
        end
        S_ABORT_END: begin
          state_r     <= S_DONE;
          rsp_valid_r <= 1'b1;
          rsp_data_r  <= 8'h00;
          rsp_error_r <= 1'b1;
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r  <= S_IDLE;
          frame_r  <= 1'b1;
          ad_out_r <= 4'hF;
          ad_oe_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_host.sv
// Randomized and directed bench for lpc_host; expected pin traces and responses come
// from a cycle-budget model of the LPC protocol kept here.
module tb_lpc_host;
  localparam int SYNC_TIMEOUT = 8;
  localparam int LWAIT_MAX    = 64;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   last_done_cyc = 0;
  logic [3:0] wait_q[$];

  lpc_host_if bus();

  lpc_host #(.SYNC_TIMEOUT(SYNC_TIMEOUT), .LWAIT_MAX(LWAIT_MAX)) dut (
    .lpc_clock(clk),
    .lpc_reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // kind: 0 good sync, 1 error sync, 2 no sync (timeout), 3 long-wait overrun.
  // Sync wait nibbles are taken from wait_q.
  task automatic run_txn(input string name, input logic [3:0] ct, input logic [31:0] a,
                         input logic [7:0] d, input logic [7:0] rd, input int kind,
                         input bit hold, input bit b2b);
    logic [3:0] drv[$];
    logic [3:0] stream[$];
    bit         wr, mem, abort;
    int         naddr, base, pre, lat, abort_at, guard, rsp_k, n_rsp, start_cyc;
    logic [7:0] exp_data, rsp_d;
    logic       exp_err, rsp_e, ready_low;
    wr    = ct[1];
    mem   = (ct[3:2] == 2'b01);
    abort = (kind >= 2);
    naddr = mem ? 8 : 4;
    base  = mem ? 17 : 13;
    pre   = base - 3 - (wr ? 0 : 2);
    drv   = {};
    drv.push_back(4'h0);
    drv.push_back(ct);
    for (int i = naddr - 1; i >= 0; i--) drv.push_back(a[i*4 +: 4]);
    if (wr) begin
      drv.push_back(d[3:0]);
      drv.push_back(d[7:4]);
    end
    drv.push_back(4'hF);
    stream = wait_q;
    if (!abort) begin
      stream.push_back((kind == 1) ? 4'hA : 4'h0);
      if (!wr) begin
        stream.push_back(rd[3:0]);
        stream.push_back(rd[7:4]);
      end
      lat      = base + wait_q.size();
      exp_err  = (kind == 1);
      exp_data = wr ? 8'h00 : rd;
      abort_at = -100;
    end else begin
      abort_at = pre + ((kind == 2) ? SYNC_TIMEOUT : LWAIT_MAX + 1);
      lat      = abort_at + 5;
      exp_err  = 1'b1;
      exp_data = 8'h00;
    end

    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check({name, " ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_cyctype_dir = ct;
    bus.req_addr        = a;
    bus.req_data        = d;
    bus.req_valid       = 1'b1;
    rsp_k = -1; n_rsp = 0; ready_low = 1'b1; rsp_d = 8'h00; rsp_e = 1'b0; start_cyc = 0;
    @(posedge clk);
    for (int k = 0; k <= lat + 1; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start_cyc = cyc;
        if (!hold) bus.req_valid = 1'b0;
        if (b2b) check({name, " start gap"}, 32'(start_cyc - last_done_cyc), 32'd2);
      end
      bus.lpc_ad_in = (k >= pre && k - pre < int'(stream.size())) ? stream[k - pre] : 4'hF;
      if (k < pre - 1)
        check($sformatf("%s lad%0d", name, k),
              32'({bus.lpc_frame, bus.lpc_ad_oe, bus.lpc_ad_out}),
              32'({(k != 0), 1'b1, drv[k]}));
      else if (abort && k >= abort_at && k < abort_at + 4)
        check($sformatf("%s abort%0d", name, k),
              32'({bus.lpc_frame, bus.lpc_ad_oe, bus.lpc_ad_out}), 32'({1'b0, 1'b1, 4'hF}));
      else
        check($sformatf("%s released%0d", name, k),
              32'({bus.lpc_frame, bus.lpc_ad_oe}), 32'({1'b1, 1'b0}));
      if (k < lat && bus.req_ready !== 1'b0) ready_low = 1'b0;
      if (bus.rsp_valid === 1'b1) begin
        n_rsp++;
        if (rsp_k < 0) begin
          rsp_k = k;
          rsp_d = bus.rsp_data;
          rsp_e = bus.rsp_error;
        end
      end
      if (k == lat + 1) check({name, " ready after"}, 32'(bus.req_ready), 32'd1);
    end
    check({name, " latency"}, 32'(rsp_k), 32'(lat));
    check({name, " rsp count"}, 32'(n_rsp), 32'd1);
    check({name, " rsp_data"}, 32'(rsp_d), 32'(exp_data));
    check({name, " rsp_error"}, 32'(rsp_e), 32'(exp_err));
    check({name, " busy"}, 32'(ready_low), 32'd1);
    last_done_cyc = start_cyc + lat;
    wait_q = {};
  endtask

  logic [3:0] cts[4] = '{4'h0, 4'h2, 4'h4, 4'h6};
  logic [3:0] wpool[6] = '{4'h5, 4'h6, 4'h1, 4'h3, 4'h9, 4'hF};

  initial begin
    int n_rsp_seen;
    rst = 1'b1;
    bus.req_valid       = 1'b0;
    bus.req_cyctype_dir = 4'h0;
    bus.req_addr        = 32'h0;
    bus.req_data        = 8'h00;
    bus.lpc_ad_in       = 4'hF;
    repeat (3) @(negedge clk);
    check("reset frame", 32'(bus.lpc_frame), 32'd1);
    check("reset oe", 32'(bus.lpc_ad_oe), 32'd0);
    check("reset ad", 32'(bus.lpc_ad_out), 32'hF);
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset rsp_data", 32'(bus.rsp_data), 32'd0);
    check("reset rsp_error", 32'(bus.rsp_error), 32'd0);
    check("reset ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    repeat (4) wait_q.push_back(4'h5);
    run_txn("t1 io rd", 4'h0, 32'h0000_7fe5, 8'h00, 8'h6c, 0, 1'b0, 1'b0);
    run_txn("t2 mem wr", 4'h6, 32'h1234_5678, 8'ha5, 8'h00, 0, 1'b0, 1'b0);
    run_txn("t3 io wr timeout", 4'h2, 32'h0000_0080, 8'h11, 8'h00, 2, 1'b0, 1'b0);
    run_txn("t4 mem rd err", 4'h4, 32'hfedc_0001, 8'h00, 8'h3c, 1, 1'b0, 1'b0);
    repeat (LWAIT_MAX + 1) wait_q.push_back(4'h6);
    run_txn("lwait abort", 4'h4, 32'h0bad_f00d, 8'h00, 8'h77, 3, 1'b0, 1'b0);

    // Reset in the middle of an io write address phase
    bus.req_cyctype_dir = 4'h2;
    bus.req_addr        = 32'h0000_abcd;
    bus.req_data        = 8'h5a;
    bus.req_valid       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5 frame after reset", 32'(bus.lpc_frame), 32'd1);
    check("t5 oe after reset", 32'(bus.lpc_ad_oe), 32'd0);
    check("t5 ready in reset", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    n_rsp_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) n_rsp_seen++;
    end
    check("t5 no rsp after reset", 32'(n_rsp_seen), 32'd0);
    run_txn("t5 io rd after reset", 4'h0, 32'h0000_0060, 8'h00, 8'h9e, 0, 1'b0, 1'b0);

    run_txn("t6 first", 4'h2, 32'h0000_1234, 8'hc3, 8'h00, 0, 1'b1, 1'b0);
    run_txn("t6 second", 4'h4, 32'h8765_4321, 8'h00, 8'h81, 0, 1'b0, 1'b1);

    for (int t = 0; t < 12; t++) begin
      int nw;
      logic [3:0]  ct;
      logic [31:0] a;
      logic [7:0]  d, rd;
      ct = cts[$urandom_range(0, 3)];
      a  = $urandom;
      d  = 8'($urandom_range(0, 255));
      rd = 8'($urandom_range(0, 255));
      nw = $urandom_range(0, 5);
      for (int i = 0; i < nw; i++) wait_q.push_back(wpool[$urandom_range(0, 5)]);
      run_txn($sformatf("rnd%0d", t), ct, a, d, rd, int'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
